// File: rtl/menu_pkg.sv
// Shared encodings for the front-panel menu: rotary encoder actions, menu states,
// LCD refresh states and audio setting indices.
package menu_pkg;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_LEFT  = 2'd1,
    ACT_RIGHT = 2'd2,
    ACT_PRESS = 2'd3
  } action_e;

  typedef enum logic {
    BROWSE = 1'b0,
    EDIT   = 1'b1
  } menu_state_e;

  typedef enum logic [1:0] {
    L_IDLE      = 2'd0,
    L_WAIT_BUSY = 2'd1,
    L_WAIT_DONE = 2'd2
  } lcd_state_e;

  typedef enum logic [1:0] {
    ITEM_VOL    = 2'd0,
    ITEM_BASS   = 2'd1,
    ITEM_TREBLE = 2'd2,
    ITEM_BAL    = 2'd3
  } item_e;

  localparam int NUM_ITEMS_DEF = 4;

endpackage

// File: rtl/lcd_refresh_sched.sv
// LCD refresh scheduler: tracks a dirty screen, issues one start per refresh,
// snapshots what to draw, and retries when lcd_busy never answers.
module lcd_refresh_sched
  import menu_pkg::*;
#(
  parameter int IDX_W     = 2,
  parameter int VAL_W     = 5,
  parameter int BUSY_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_dirty,
  input  logic [IDX_W-1:0] cur_item,
  input  logic [VAL_W-1:0] cur_value,
  input  logic             cur_edit,
  input  logic             lcd_busy,
  output logic             lcd_start,
  output logic [IDX_W-1:0] lcd_item,
  output logic [VAL_W-1:0] lcd_value,
  output logic             lcd_edit
);

  localparam int WAIT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

  lcd_state_e        st_q, st_d;
  logic              dirty_q, dirty_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              start_d;

  // NOTE: every output of this block is assigned up front, so no path can infer a latch.
  always_comb begin
    st_d    = st_q;
    dirty_d = dirty_q;
    wait_d  = wait_q;
    start_d = 1'b0;
    case (st_q)
      L_IDLE: begin
        if (dirty_q && !lcd_busy) begin
          start_d = 1'b1;
          dirty_d = 1'b0;
          wait_d  = '0;
          st_d    = L_WAIT_BUSY;
        end
      end
      L_WAIT_BUSY: begin
        if (lcd_busy) begin
          st_d = L_WAIT_DONE;
        end else if (wait_q == WAIT_LAST) begin
          dirty_d = 1'b1;
          st_d    = L_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      L_WAIT_DONE: begin
        if (!lcd_busy) st_d = L_IDLE;
      end
      default: st_d = L_IDLE;
    endcase
    // A change landing on the snapshot cycle must still be drawn later.
    if (set_dirty) dirty_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= L_IDLE;
      dirty_q   <= 1'b1;
      wait_q    <= '0;
      lcd_start <= 1'b0;
      lcd_item  <= '0;
      lcd_value <= '0;
      lcd_edit  <= 1'b0;
    end else begin
      st_q      <= st_d;
      dirty_q   <= dirty_d;
      wait_q    <= wait_d;
      lcd_start <= start_d;
      if (start_d) begin
        lcd_item  <= cur_item;
        lcd_value <= cur_value;
        lcd_edit  <= cur_edit;
      end
    end
  end

endmodule

// File: rtl/menu_controller.sv
// Two-level BROWSE/EDIT menu over the audio settings, driven by rotary encoder
// events, with an EDIT idle timeout and coalesced LCD refresh requests.
module menu_controller
  import menu_pkg::*;
#(
  parameter int NUM_ITEMS    = NUM_ITEMS_DEF,
  parameter int VAL_W        = 5,
  parameter int VAL_MAX      = 31,
  parameter int VAL_INIT     = 16,
  parameter int EDIT_TIMEOUT = 500000000,
  parameter int BUSY_WAIT    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   action,
  input  logic                         start,
  output logic [NUM_ITEMS*VAL_W-1:0]   values_flat,
  output logic [$clog2(NUM_ITEMS)-1:0] cursor,
  output logic                         edit_mode,
  output logic                         lcd_start,
  output logic [$clog2(NUM_ITEMS)-1:0] lcd_item,
  output logic [VAL_W-1:0]             lcd_value,
  output logic                         lcd_edit,
  input  logic                         lcd_busy
);

  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam logic [IDX_W-1:0] CUR_LAST = IDX_W'(NUM_ITEMS - 1);
  localparam logic [VAL_W-1:0] V_MAX    = VAL_W'(VAL_MAX);
  localparam logic [VAL_W-1:0] V_INIT   = VAL_W'(VAL_INIT);
  localparam logic [31:0]      TMO_LAST = (EDIT_TIMEOUT > 0) ? 32'(EDIT_TIMEOUT - 1) : 32'd0;

  menu_state_e      state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic [VAL_W-1:0] values_q [NUM_ITEMS];
  logic [VAL_W-1:0] sel_val, sel_val_d;
  logic [31:0]      tmo_q, tmo_d;
  action_e          act;
  logic             event_v;
  logic             changed;

  assign act     = action_e'(action);
  assign event_v = start && (act != ACT_NONE);
  assign sel_val = values_q[cursor_q];

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    sel_val_d = sel_val;
    tmo_d     = '0;
    if (event_v) begin
      // An event always wins over a coinciding timeout and restarts the idle count.
      case (state_q)
        BROWSE: begin
          case (act)
            ACT_LEFT:  cursor_d = (cursor_q == '0) ? CUR_LAST : cursor_q - 1'b1;
            ACT_RIGHT: cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1;
            ACT_PRESS: state_d  = EDIT;
            default:   ;
          endcase
        end
        EDIT: begin
          case (act)
            ACT_LEFT:  if (sel_val != '0) sel_val_d = sel_val - 1'b1;
            ACT_RIGHT: if (sel_val < V_MAX) sel_val_d = sel_val + 1'b1;
            ACT_PRESS: state_d = BROWSE;
            default:   ;
          endcase
        end
        default: state_d = BROWSE;
      endcase
    end else if (state_q == EDIT) begin
      if ((EDIT_TIMEOUT != 0) && (tmo_q == TMO_LAST)) state_d = BROWSE;
      else tmo_d = tmo_q + 32'd1;
    end
  end

  assign changed = (state_d != state_q) || (cursor_d != cursor_q) || (sel_val_d != sel_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BROWSE;
      cursor_q <= '0;
      tmo_q    <= '0;
      // NOTE: the settings are a few flops rather than a RAM, so each entry gets a reset value.
      for (int i = 0; i < NUM_ITEMS; i++) values_q[i] <= V_INIT;
    end else begin
      state_q            <= state_d;
      cursor_q           <= cursor_d;
      tmo_q              <= tmo_d;
      values_q[cursor_q] <= sel_val_d;
    end
  end

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_flat
    assign values_flat[g*VAL_W +: VAL_W] = values_q[g];
  end

  assign cursor    = cursor_q;
  assign edit_mode = (state_q == EDIT);

  lcd_refresh_sched #(
    .IDX_W    (IDX_W),
    .VAL_W    (VAL_W),
    .BUSY_WAIT(BUSY_WAIT)
  ) u_sched (
    .clk      (clk),
    .rst      (rst),
    .set_dirty(changed),
    .cur_item (cursor_q),
    .cur_value(sel_val),
    .cur_edit (state_q == EDIT),
    .lcd_busy (lcd_busy),
    .lcd_start(lcd_start),
    .lcd_item (lcd_item),
    .lcd_value(lcd_value),
    .lcd_edit (lcd_edit)
  );

endmodule
